irq_ctrl: RTL

Interrupt controller that aggregates `NUM_SRC` peripheral interrupt sources into the single `irq` pin carried by the interrupt request interface toward the CPU agent. It latches requests into a pending register, applies a software-writable mask, and selects the highest-priority unmasked source. It sequences a claim/complete handshake so that exactly one interrupt is in service at a time.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_if.sv | 8 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared types, limits and priority helper for irq_ctrl
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } irq_state_e;

  localparam int MAX_SRC = 32;
  localparam int SEL_W   = $clog2(MAX_SRC);

  // Lowest set index wins; an all-zero vector returns 0 (callers gate with a valid flag).
  function automatic logic [SEL_W-1:0] prio_sel(input logic [MAX_SRC-1:0] vec);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_if.sv
// rtl/irq_if.sv - interrupt request interface carrying irq toward the CPU agent
interface irq_if (
  input logic clk
);
  logic irq;

  modport cpu (input clk, input irq);
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index priority encoder with valid flag
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic            vld,
  output logic [ID_W-1:0] id
);

  logic [MAX_SRC-1:0] vec_ext;

  always_comb vec_ext = MAX_SRC'(vec);

  assign vld = |vec;
  assign id  = ID_W'(prio_sel(vec_ext));

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - pending/mask/priority interrupt controller with claim/complete handshake
// Optional IRQ_CTRL_EDGE_EN adds per-source edge-triggered mode via edge_mode.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef IRQ_CTRL_EDGE_EN
  input  logic [NUM_SRC-1:0] edge_mode,
`endif
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq,
  input  logic               claim,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete,
  output logic               busy
);

  irq_state_e         state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] active;
  logic               sel_vld;
  logic [ID_W-1:0]    sel;
  logic               take;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_hist <= '0;
    else        src_hist <= src_q;
  end

  assign set_vec = (src_q & ~src_hist & edge_mode) | (src_q & ~edge_mode);
`else
  assign set_vec = src_q;
`endif

  assign active = pending & mask;

  irq_prio_enc #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .vec (active),
    .vld (sel_vld),
    .id  (sel)
  );

  // A claim only counts while requesting something that is still eligible.
  assign take    = (state == REQ) && claim && sel_vld;
  assign clr_vec = take ? (NUM_SRC'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      mask    <= '0;
      pending <= '0;
    end else begin
      src_q   <= src_irq;
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq      <= 1'b0;
      busy     <= 1'b0;
      claim_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (!sel_vld) begin
            state <= IDLE;
            irq   <= 1'b0;
          end else if (claim) begin
            state    <= SVC;
            irq      <= 1'b0;
            busy     <= 1'b1;
            claim_id <= sel;
          end
        end
        SVC: begin
          if (complete) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
